// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite commit controller: FSM states,
// CTRL register bit positions and walk-animation frame codes.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } commit_state_e;

    localparam int unsigned CTRL_COMMIT  = 0;
    localparam int unsigned CTRL_ANIM_EN = 1;

    localparam logic [1:0] WALK_NEUTRAL = 2'd0;
    localparam logic [1:0] WALK_LEFT    = 2'd1;
    localparam logic [1:0] WALK_RIGHT   = 2'd2;

    function automatic logic [1:0] next_walk(input logic [1:0] cur);
        case (cur)
            WALK_NEUTRAL: return WALK_LEFT;
            WALK_LEFT:    return WALK_RIGHT;
            default:      return WALK_NEUTRAL;
        endcase
    endfunction

endpackage

// File: rtl/sprite_anim_seq.sv
// Walk-animation sequencer: divides vblank rises by ANIM_DIV and steps the
// dino frame select NEUTRAL -> LEFT -> RIGHT -> NEUTRAL while enabled.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int unsigned ANIM_DIV = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vb_rise,
    input  logic       anim_en,
    output logic [1:0] anim_state
);

    localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

    logic [7:0] anim_div_cnt_q, anim_div_cnt_d;
    logic [1:0] anim_state_q, anim_state_d;

    always_comb begin
        anim_div_cnt_d = anim_div_cnt_q;
        anim_state_d   = anim_state_q;
        if (vb_rise && anim_en) begin
            if (anim_div_cnt_q >= DIV_LAST) begin
                anim_div_cnt_d = '0;
                anim_state_d   = next_walk(anim_state_q);
            end else begin
                anim_div_cnt_d = anim_div_cnt_q + 8'd1;
            end
        end
        // The unused code 3 is recovered even while the animation is paused.
        if (anim_state_d == 2'd3) begin
            anim_state_d = WALK_NEUTRAL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anim_div_cnt_q <= '0;
            anim_state_q   <= WALK_NEUTRAL;
        end else begin
            anim_div_cnt_q <= anim_div_cnt_d;
            anim_state_q   <= anim_state_d;
        end
    end

    assign anim_state = anim_state_q;

endmodule

// File: rtl/sprite_commit_ctrl.sv
// Double-buffered sprite/score registers committed to the active bank on vblank.
// Define SPRITE_AUTO_COMMIT_EN to also commit any dirty shadow bank automatically.
module sprite_commit_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ANIM_DIV = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [4:0]            address,
    input  logic [31:0]           writedata,
    input  logic                  vblank,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic [1:0]            anim_state,
    output logic                  commit_pulse,
    output logic                  pending,
    output logic [15:0]           frame_count
);

    localparam logic [4:0] CTRL_ADDR = 5'(NUM_REGS);

    logic [7:0]    shadow_q [NUM_REGS];
    logic [7:0]    shadow_d [NUM_REGS];
    logic [7:0]    active_q [NUM_REGS];
    logic [7:0]    active_d [NUM_REGS];
    commit_state_e state_q, state_d;
    logic          vblank_q;
    logic          anim_en_q, anim_en_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          commit_pulse_q, commit_pulse_d;
    logic          pending_q, pending_d;
    logic          bus_wr, shadow_wr, ctrl_wr, commit_req, vb_rise;
    logic          unused_wdata;
`ifdef SPRITE_AUTO_COMMIT_EN
    logic          dirty_q, dirty_d;
`endif

    always_comb begin
        bus_wr     = chipselect & write;
        shadow_wr  = bus_wr && (address < CTRL_ADDR);
        ctrl_wr    = bus_wr && (address == CTRL_ADDR);
        commit_req = ctrl_wr && writedata[CTRL_COMMIT];
        vb_rise    = vblank & ~vblank_q;
    end

    assign unused_wdata = ^writedata[31:8];

    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        state_d       = state_q;
        anim_en_d     = anim_en_q;
        frame_count_d = frame_count_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (shadow_wr && (address == 5'(i))) begin
                shadow_d[i] = writedata[7:0];
            end
        end
        if (ctrl_wr) begin
            anim_en_d = writedata[CTRL_ANIM_EN];
        end
        if (vb_rise) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = ARMED;
                end
`ifdef SPRITE_AUTO_COMMIT_EN
                else if (vb_rise && dirty_q) begin
                    state_d = COMMIT;
                end
`endif
            end
            ARMED: begin
                if (vb_rise) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Copy takes the registered shadow, so a same-cycle write waits for the next commit.
                active_d = shadow_q;
                state_d  = commit_req ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
        commit_pulse_d = (state_d == COMMIT);
        pending_d      = (state_d == ARMED);
    end

`ifdef SPRITE_AUTO_COMMIT_EN
    always_comb begin
        dirty_d = dirty_q;
        if (state_q == COMMIT) begin
            dirty_d = 1'b0;
        end
        if (shadow_wr) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dirty_q <= 1'b0;
        end else begin
            dirty_q <= dirty_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q       <= '{default: '0};
            active_q       <= '{default: '0};
            state_q        <= IDLE;
            vblank_q       <= 1'b0;
            anim_en_q      <= 1'b0;
            frame_count_q  <= '0;
            commit_pulse_q <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            state_q        <= state_d;
            vblank_q       <= vblank;
            anim_en_q      <= anim_en_d;
            frame_count_q  <= frame_count_d;
            commit_pulse_q <= commit_pulse_d;
            pending_q      <= pending_d;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_out[8*i +: 8] = active_q[i];
        end
    end

    assign commit_pulse = commit_pulse_q;
    assign pending      = pending_q;
    assign frame_count  = frame_count_q;

    sprite_anim_seq #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .vb_rise    (vb_rise),
        .anim_en    (anim_en_q),
        .anim_state (anim_state)
    );

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Directed bench for sprite_commit_ctrl; expected active banks are queued at
// stimulus time and compared by a monitor whenever commit_pulse is seen.
module tb_sprite_commit_ctrl;

    localparam int unsigned NUM_REGS = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         chipselect;
    logic         write;
    logic [4:0]   address;
    logic [31:0]  writedata;
    logic         vblank;
    logic [127:0] regs_out;
    logic [1:0]   anim_state;
    logic         commit_pulse;
    logic         pending;
    logic [15:0]  frame_count;

    int unsigned  pass_cnt  = 0;
    int unsigned  total_cnt = 0;
    logic [7:0]   sh_model [NUM_REGS];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    sprite_commit_ctrl #(
        .NUM_REGS (NUM_REGS),
        .ANIM_DIV (6)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .chipselect   (chipselect),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .vblank       (vblank),
        .regs_out     (regs_out),
        .anim_state   (anim_state),
        .commit_pulse (commit_pulse),
        .pending      (pending),
        .frame_count  (frame_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [127:0] pack_shadow();
        logic [127:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[8*i +: 8] = sh_model[i];
        return r;
    endfunction

    task automatic drive_wr(input logic [4:0] addr, input logic [31:0] data);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = addr;
        writedata  = data;
        if (addr < 5'(NUM_REGS)) sh_model[addr] = data[7:0];
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        drive_wr(addr, data);
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic vb_pulse();
        @(negedge clk);
        vblank = 1'b1;
        repeat (3) @(negedge clk);
        vblank = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: each commit pulse consumes one queued bank, compared once the copy lands.
    initial begin : monitor
        logic [127:0] exp_bank;
        forever begin
            @(negedge clk);
            if (reset_n && commit_pulse) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit_pulse", commit_pulse, 1'b0);
                end else begin
                    exp_bank = exp_q.pop_front();
                    @(negedge clk);
                    check("commit_bank", regs_out, exp_bank);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: got no finish, expected finish within 500us");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int        chk_p [6] = '{5, 6, 11, 12, 17, 18};
        logic [1:0] chk_s [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

        reset_n = 1'b0; chipselect = 1'b0; write = 1'b0;
        address = '0; writedata = '0; vblank = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) sh_model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_regs_out", regs_out, '0);
        check("rst_pending", pending, 1'b0);
        check("rst_commit_pulse", commit_pulse, 1'b0);
        check("rst_anim_state", anim_state, 2'd0);
        check("rst_frame_count", frame_count, 16'd0);
        reset_n = 1'b1;

        // Animation: ANIM_DIV=6, 18 vblank pulses
        bus_write(5'd16, 32'h02);
        for (int p = 1; p <= 18; p++) begin
            vb_pulse();
            for (int k = 0; k < 6; k++)
                if (chk_p[k] == p) check($sformatf("anim_state_p%0d", p), anim_state, chk_s[k]);
        end
        check("frame_count_18", frame_count, 16'd18);

        // Shadow write alone never reaches the active bank
        bus_write(5'd0, 32'h64);
        repeat (1000) @(negedge clk);
        check("no_commit_reg0", regs_out[7:0], 8'h00);
        check("no_commit_pending", pending, 1'b0);
        bus_write(5'd17, 32'h01);
        bus_write(5'd31, 32'h01);
        @(negedge clk);
        check("bad_addr_pending", pending, 1'b0);
        vb_pulse();
        check("idle_vb_reg0", regs_out[7:0], 8'h00);
        check("frame_count_19", frame_count, 16'd19);

        // Basic commit
        bus_write(5'd16, 32'h01);
        check("armed_pending", pending, 1'b1);
        exp_q.push_back(pack_shadow());
        @(negedge clk); vblank = 1'b1;
        @(negedge clk);
        check("commit_pulse_hi", commit_pulse, 1'b1);
        check("reg0_before_copy", regs_out[7:0], 8'h00);
        @(negedge clk);
        check("reg0_committed", regs_out[7:0], 8'h64);
        check("pending_cleared", pending, 1'b0);
        check("commit_pulse_lo", commit_pulse, 1'b0);
        vblank = 1'b0;
        repeat (2) @(negedge clk);

        // Shadow write during the COMMIT cycle
        bus_write(5'd16, 32'h01);
        exp_q.push_back(pack_shadow());
        @(negedge clk); vblank = 1'b1;
        @(negedge clk);
        check("commit_pulse_hi2", commit_pulse, 1'b1);
        drive_wr(5'd1, 32'h55);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        check("reg1_keeps_old", regs_out[15:8], 8'h00);
        vblank = 1'b0;
        repeat (2) @(negedge clk);

        // Later commit picks 0x55; CTRL commit in the COMMIT cycle re-arms
        bus_write(5'd16, 32'h01);
        exp_q.push_back(pack_shadow());
        @(negedge clk); vblank = 1'b1;
        @(negedge clk);
        check("commit_pulse_hi3", commit_pulse, 1'b1);
        drive_wr(5'd16, 32'h01);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        check("reg1_committed", regs_out[15:8], 8'h55);
        check("rearm_in_commit", pending, 1'b1);
        vblank = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(pack_shadow());
        vb_pulse();
        check("rearm_consumed", pending, 1'b0);

        // Reset while armed
        bus_write(5'd16, 32'h02);
        repeat (6) vb_pulse();
        check("anim_state_pre_rst", anim_state, 2'd1);
        check("frame_count_29", frame_count, 16'd29);
        bus_write(5'd2, 32'h7F);
        bus_write(5'd16, 32'h01);
        check("armed_pre_rst", pending, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_regs_out", regs_out, '0);
        check("mid_rst_pending", pending, 1'b0);
        check("mid_rst_anim_state", anim_state, 2'd0);
        check("mid_rst_frame_count", frame_count, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) sh_model[i] = 8'h00;
        vb_pulse();
        check("post_rst_regs_out", regs_out, '0);
        check("post_rst_pending", pending, 1'b0);
        check("post_rst_frame_count", frame_count, 16'd1);

`ifdef SPRITE_AUTO_COMMIT_EN
        bus_write(5'd3, 32'h10);
        exp_q.push_back(pack_shadow());
        @(negedge clk); vblank = 1'b1;
        @(negedge clk);
        check("auto_commit_pulse", commit_pulse, 1'b1);
        @(negedge clk);
        check("auto_reg3", regs_out[31:24], 8'h10);
        vblank = 1'b0;
        repeat (2) @(negedge clk);
`else
        bus_write(5'd3, 32'h10);
        vb_pulse();
        check("no_auto_reg3", regs_out[31:24], 8'h00);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
